// File: rtl/ascensor_pkg.sv
// rtl/ascensor_pkg.sv - shared types and default sizes for the elevator scheduler
// Purpose: FSM state and travel-direction enums plus building defaults.
// Ports:   none (package).
package ascensor_pkg;

   typedef enum logic [1:0] {REPOSO, SUBIENDO, BAJANDO, PUERTA} estado_t;
   typedef enum logic       {UP, DOWN} dir_t;

   localparam int NUM_PISOS_DEF   = 10;
   localparam int PISO_W_DEF      = 4;
   localparam int DOOR_CYCLES_DEF = 8;

endpackage

// File: rtl/temporizador_puerta.sv
// rtl/temporizador_puerta.sv - door-open down-counter with reload and done pulse
// Purpose: counts the cycles a door stays open at a stop.
// Ports:   clk, rst_n (async, active low)
//          carga  in  : load CICLOS-1 so the door stays open CICLOS cycles
//          en     in  : count while the door is open
//          hecho  out : high during the last open cycle
module temporizador_puerta #(
   parameter int CICLOS = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic carga,
   input  logic en,
   output logic hecho
);

   localparam int CNT_W = (CICLOS > 1) ? $clog2(CICLOS) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (carga) begin
         cnt_d = CNT_W'(CICLOS - 1);
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hecho = en && (cnt_q == '0);

endmodule

// File: rtl/planificador_ascensor.sv
// rtl/planificador_ascensor.sv - SCAN elevator scheduler driving motor and door
// Purpose: latches floor calls, moves the car with a SCAN FSM, opens the door
//          at requested floors and clears requests as they are served.
// Ports:   clk, rst_n (async, active low)
//          botones[NUM_PISOS]  in  : floor buttons, level
//          llegada_piso        in  : pulse, car reached the next floor
//          boton_abrir         in  : door-reopen button (only with DOOR_REOPEN_EN)
//          motor_subir/bajar   out : motor drive up / down
//          puerta_abierta      out : door open
//          piso_actual         out : current floor
//          solicitudes         out : pending requests
// Config:  DOOR_REOPEN_EN adds boton_abrir.
module planificador_ascensor
   import ascensor_pkg::*;
#(
   parameter int NUM_PISOS   = NUM_PISOS_DEF,
   parameter int PISO_W      = PISO_W_DEF,
   parameter int DOOR_CYCLES = DOOR_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_PISOS-1:0] botones,
   input  logic                 llegada_piso,
`ifdef DOOR_REOPEN_EN
   input  logic                 boton_abrir,
`endif
   output logic                 motor_subir,
   output logic                 motor_bajar,
   output logic                 puerta_abierta,
   output logic [PISO_W-1:0]    piso_actual,
   output logic [NUM_PISOS-1:0] solicitudes
);

   localparam logic [PISO_W-1:0] PISO_TOPE = PISO_W'(NUM_PISOS - 1);
   localparam logic [PISO_W-1:0] UNO       = PISO_W'(1);

   estado_t              estado_q, estado_d, dec_estado;
   dir_t                 dir_q, dir_d, dec_dir;
   logic [PISO_W-1:0]    piso_q, piso_d, piso_mas, piso_menos;
   logic [NUM_PISOS-1:0] solicitudes_q, solicitudes_d;
   logic [NUM_PISOS-1:0] mask_arriba, mask_abajo, clr;
   logic                 hay_aqui, hay_arriba, hay_abajo;
   logic                 carga, hecho, en_puerta, abrir;

`ifdef DOOR_REOPEN_EN
   assign abrir = boton_abrir;
`else
   assign abrir = 1'b0;
`endif

   assign en_puerta  = (estado_q == PUERTA);
   assign piso_mas   = piso_q + UNO;
   assign piso_menos = piso_q - UNO;

   // Floor masks relative to the car; clr absorbs presses at the open door.
   always_comb begin
      mask_arriba = '0;
      mask_abajo  = '0;
      clr         = '0;
      for (int i = 0; i < NUM_PISOS; i++) begin
         mask_arriba[i] = (i > int'(piso_q));
         mask_abajo[i]  = (i < int'(piso_q));
         clr[i]         = en_puerta && (i == int'(piso_q));
      end
   end

   assign hay_aqui      = solicitudes_q[piso_q];
   assign hay_arriba    = |(solicitudes_q & mask_arriba);
   assign hay_abajo     = |(solicitudes_q & mask_abajo);
   assign solicitudes_d = (solicitudes_q | botones) & ~clr;

   // Decision rule: serve here, else keep sweeping, else turn toward work.
   always_comb begin
      dec_estado = REPOSO;
      dec_dir    = dir_q;
      if (hay_aqui) begin
         dec_estado = PUERTA;
      end else if (hay_arriba && hay_abajo) begin
         dec_estado = (dir_q == UP) ? SUBIENDO : BAJANDO;
      end else if (hay_arriba) begin
         dec_estado = SUBIENDO;
         dec_dir    = UP;
      end else if (hay_abajo) begin
         dec_estado = BAJANDO;
         dec_dir    = DOWN;
      end
   end

   // Next-state process.
   always_comb begin
      estado_d = estado_q;
      dir_d    = dir_q;
      piso_d   = piso_q;
      carga    = 1'b0;
      case (estado_q)
         REPOSO: begin
            if (abrir) begin
               estado_d = PUERTA;
               carga    = 1'b1;
            end else begin
               estado_d = dec_estado;
               dir_d    = dec_dir;
               carga    = (dec_estado == PUERTA);
            end
         end
         SUBIENDO: begin
            if (llegada_piso && (piso_q != PISO_TOPE)) begin
               piso_d = piso_mas;
               if (solicitudes_q[piso_mas]) begin
                  estado_d = PUERTA;
                  carga    = 1'b1;
               end
            end
         end
         BAJANDO: begin
            if (llegada_piso && (piso_q != '0)) begin
               piso_d = piso_menos;
               if (solicitudes_q[piso_menos]) begin
                  estado_d = PUERTA;
                  carga    = 1'b1;
               end
            end
         end
         PUERTA: begin
            // Reopen outranks expiry so a press on the last cycle still holds the door.
            if (abrir) begin
               carga = 1'b1;
            end else if (hecho) begin
               estado_d = dec_estado;
               dir_d    = dec_dir;
               carga    = (dec_estado == PUERTA);
            end
         end
         default: estado_d = REPOSO;
      endcase
   end

   // State register process.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q      <= REPOSO;
         dir_q         <= UP;
         piso_q        <= '0;
         solicitudes_q <= '0;
      end else begin
         estado_q      <= estado_d;
         dir_q         <= dir_d;
         piso_q        <= piso_d;
         solicitudes_q <= solicitudes_d;
      end
   end

   // Output process: everything decodes straight from flops.
   always_comb begin
      motor_subir    = (estado_q == SUBIENDO);
      motor_bajar    = (estado_q == BAJANDO);
      puerta_abierta = (estado_q == PUERTA);
      piso_actual    = piso_q;
      solicitudes    = solicitudes_q;
   end

   temporizador_puerta #(
      .CICLOS (DOOR_CYCLES)
   ) u_temporizador (
      .clk   (clk),
      .rst_n (rst_n),
      .carga (carga),
      .en    (en_puerta),
      .hecho (hecho)
   );

endmodule

// File: tb/tb_planificador_ascensor.sv
// tb/tb_planificador_ascensor.sv - self-checking bench for planificador_ascensor
module tb_planificador_ascensor;

   localparam int NP = 10;
   localparam int PW = 4;
   localparam int DC = 8;
   localparam int VW = 3 + PW + NP;
`ifdef DOOR_REOPEN_EN
   localparam bit REOPEN = 1'b1;
`else
   localparam bit REOPEN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NP-1:0] botones = '0;
   logic          llegada_piso = 1'b0;
   logic          boton_abrir = 1'b0;
   logic          motor_subir, motor_bajar, puerta_abierta;
   logic [PW-1:0] piso_actual;
   logic [NP-1:0] solicitudes;
   logic [VW-1:0] dut_vec;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   planificador_ascensor #(
      .NUM_PISOS   (NP),
      .PISO_W      (PW),
      .DOOR_CYCLES (DC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .botones        (botones),
      .llegada_piso   (llegada_piso),
`ifdef DOOR_REOPEN_EN
      .boton_abrir    (boton_abrir),
`endif
      .motor_subir    (motor_subir),
      .motor_bajar    (motor_bajar),
      .puerta_abierta (puerta_abierta),
      .piso_actual    (piso_actual),
      .solicitudes    (solicitudes)
   );

   assign dut_vec = {motor_subir, motor_bajar, puerta_abierta, piso_actual, solicitudes};

   // Reference model: car floor, activity (0 idle, 1 up, 2 down, 3 door),
   // sweep direction, door cycles left, and the set of pending calls.
   int m_floor, m_mode, m_left;
   bit m_dirup;
   bit m_pend [NP];

   task automatic m_reset();
      m_floor = 0; m_mode = 0; m_left = 0; m_dirup = 1'b1;
      for (int i = 0; i < NP; i++) m_pend[i] = 1'b0;
   endtask

   task automatic m_decide();
      bit arr, abj;
      arr = 1'b0; abj = 1'b0;
      for (int i = 0; i < NP; i++) begin
         if (m_pend[i] && i > m_floor) arr = 1'b1;
         if (m_pend[i] && i < m_floor) abj = 1'b1;
      end
      if (m_pend[m_floor]) begin m_mode = 3; m_left = DC; end
      else if (arr && abj) m_mode = m_dirup ? 1 : 2;
      else if (arr) begin m_mode = 1; m_dirup = 1'b1; end
      else if (abj) begin m_mode = 2; m_dirup = 1'b0; end
      else m_mode = 0;
   endtask

   task automatic m_step(input logic [NP-1:0] b, input logic ll, input logic ab);
      bit nxt [NP];
      for (int i = 0; i < NP; i++) begin
         nxt[i] = m_pend[i] | b[i];
         if (m_mode == 3 && i == m_floor) nxt[i] = 1'b0;
      end
      case (m_mode)
         0: if (ab) begin m_mode = 3; m_left = DC; end else m_decide();
         1: if (ll && m_floor < NP - 1) begin
               m_floor++;
               if (m_pend[m_floor]) begin m_mode = 3; m_left = DC; end
            end
         2: if (ll && m_floor > 0) begin
               m_floor--;
               if (m_pend[m_floor]) begin m_mode = 3; m_left = DC; end
            end
         default: if (ab) m_left = DC; else if (m_left == 1) m_decide(); else m_left--;
      endcase
      m_pend = nxt;
   endtask

   function automatic logic [VW-1:0] m_vec();
      logic [NP-1:0] s;
      for (int i = 0; i < NP; i++) s[i] = m_pend[i];
      return {(m_mode == 1), (m_mode == 2), (m_mode == 3), PW'(m_floor), s};
   endfunction

   function automatic logic [NP-1:0] onehot(input int f);
      logic [NP-1:0] v;
      v = '0;
      v[f] = 1'b1;
      return v;
   endfunction

   task automatic ciclo(input logic [NP-1:0] b, input logic ll, input logic ab);
      botones = b; llegada_piso = ll; boton_abrir = ab;
      @(posedge clk);
      if (rst_n) m_step(b, ll, ab & REOPEN);
      #1;
      botones = '0; llegada_piso = 1'b0; boton_abrir = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; botones = '0; llegada_piso = 1'b0; boton_abrir = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_reset();
   endtask

   task automatic esperar_reposo(input int max, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < max && !ok; k++) begin
         if (!motor_subir && !motor_bajar && !puerta_abierta) ok = 1'b1;
         else ciclo('0, 1'b1, 1'b0);
      end
      if (!motor_subir && !motor_bajar && !puerta_abierta) ok = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dut_vec !== '0) begin
         errors++; $display("FAIL reset_outputs: got %b expected %b", dut_vec, {VW{1'b0}});
      end
   endtask

   task automatic test_mismo_piso();
      int abiertos;
      bit ok;
      ciclo(onehot(0), 1'b0, 1'b0);
      checks++;
      if (solicitudes !== onehot(0) || puerta_abierta !== 1'b0) begin
         errors++; $display("FAIL t1_latch: got sol=%b door=%b expected sol=%b door=0", solicitudes, puerta_abierta, onehot(0));
      end
      ciclo('0, 1'b0, 1'b0);
      checks++;
      if (puerta_abierta !== 1'b1) begin
         errors++; $display("FAIL t1_door_latency: got %b expected 1", puerta_abierta);
      end
      abiertos = 1;
      for (int k = 0; k < 40 && puerta_abierta; k++) begin
         ciclo('0, 1'b0, 1'b0);
         if (puerta_abierta) abiertos++;
      end
      checks++;
      if (abiertos != DC) begin
         errors++; $display("FAIL t1_door_len: got %0d expected %0d", abiertos, DC);
      end
      esperar_reposo(5, ok);
      checks++;
      if (!ok || dut_vec !== m_vec() || solicitudes !== '0) begin
         errors++; $display("FAIL t1_idle: got %b expected %b", dut_vec, m_vec());
      end
   endtask

   task automatic test_subir();
      bit ok;
      ciclo(onehot(3), 1'b0, 1'b0);
      ciclo('0, 1'b0, 1'b0);
      checks++;
      if (motor_subir !== 1'b1 || motor_bajar !== 1'b0) begin
         errors++; $display("FAIL t2_motor: got up=%b down=%b expected up=1 down=0", motor_subir, motor_bajar);
      end
      for (int p = 0; p < 3; p++) begin
         ciclo('0, 1'b0, 1'b0);
         ciclo('0, 1'b1, 1'b0);
      end
      checks++;
      if (piso_actual !== PW'(3) || motor_subir !== 1'b0 || motor_bajar !== 1'b0 || puerta_abierta !== 1'b1) begin
         errors++; $display("FAIL t2_arrive: got floor=%0d up=%b down=%b door=%b expected floor=3 up=0 down=0 door=1",
                            piso_actual, motor_subir, motor_bajar, puerta_abierta);
      end
      checks++;
      if (dut_vec !== m_vec()) begin
         errors++; $display("FAIL t2_model: got %b expected %b", dut_vec, m_vec());
      end
      esperar_reposo(60, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL t2_timeout: got busy expected idle");
      end
   endtask

   task automatic test_scan();
      int servidos[$];
      bit prev, viol;
      ciclo(onehot(5), 1'b0, 1'b0);
      ciclo('0, 1'b0, 1'b0);
      for (int k = 0; k < 20 && !puerta_abierta; k++) ciclo('0, 1'b1, 1'b0);
      checks++;
      if (piso_actual !== PW'(5) || puerta_abierta !== 1'b1) begin
         errors++; $display("FAIL t3_at5: got floor=%0d door=%b expected floor=5 door=1", piso_actual, puerta_abierta);
      end
      ciclo(onehot(2) | onehot(7), 1'b0, 1'b0);
      viol = 1'b0;
      for (int k = 0; k < 300 && !(servidos.size() == 2 && !puerta_abierta && !motor_subir && !motor_bajar); k++) begin
         prev = puerta_abierta;
         ciclo('0, (k % 3) == 0, 1'b0);
         if (puerta_abierta && !prev) servidos.push_back(int'(piso_actual));
         if (puerta_abierta && (motor_subir || motor_bajar)) viol = 1'b1;
         if (motor_subir && motor_bajar) viol = 1'b1;
      end
      checks++;
      if (servidos.size() != 2 || servidos[0] != 7 || servidos[1] != 2) begin
         errors++; $display("FAIL t3_order: got %p expected '{7, 2}", servidos);
      end
      checks++;
      if (viol) begin
         errors++; $display("FAIL t3_motor_door: got overlap=1 expected 0");
      end
      checks++;
      if (dut_vec !== m_vec() || solicitudes !== '0) begin
         errors++; $display("FAIL t3_model: got %b expected %b", dut_vec, m_vec());
      end
   endtask

   task automatic test_ignorar();
      bit ok;
      for (int k = 0; k < 3; k++) ciclo('0, 1'b1, 1'b0);
      checks++;
      if (piso_actual !== PW'(2) || dut_vec !== m_vec()) begin
         errors++; $display("FAIL t4_idle_pulse: got floor=%0d expected 2", piso_actual);
      end
      ciclo(onehot(9), 1'b1, 1'b0);
      for (int k = 0; k < 30 && !puerta_abierta; k++) ciclo('0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) ciclo('0, 1'b1, 1'b0);
      checks++;
      if (piso_actual !== PW'(9) || puerta_abierta !== 1'b1) begin
         errors++; $display("FAIL t4_top_door: got floor=%0d door=%b expected floor=9 door=1", piso_actual, puerta_abierta);
      end
      esperar_reposo(30, ok);
      for (int k = 0; k < 3; k++) ciclo('0, 1'b1, 1'b0);
      checks++;
      if (!ok || piso_actual !== PW'(9) || dut_vec !== m_vec()) begin
         errors++; $display("FAIL t4_top_idle: got floor=%0d ok=%b expected floor=9 ok=1", piso_actual, ok);
      end
   endtask

   task automatic test_reset_viaje();
      ciclo(onehot(0), 1'b0, 1'b0);
      ciclo('0, 1'b0, 1'b0);
      for (int k = 0; k < 20 && piso_actual !== PW'(6); k++) ciclo('0, 1'b1, 1'b0);
      checks++;
      if (piso_actual !== PW'(6) || motor_bajar !== 1'b1) begin
         errors++; $display("FAIL t5_setup: got floor=%0d down=%b expected floor=6 down=1", piso_actual, motor_bajar);
      end
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      checks++;
      if (dut_vec !== '0) begin
         errors++; $display("FAIL t5_async_reset: got %b expected %b", dut_vec, {VW{1'b0}});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ciclo('0, 1'b1, 1'b0);
      checks++;
      if (dut_vec !== m_vec()) begin
         errors++; $display("FAIL t5_after: got %b expected %b", dut_vec, m_vec());
      end
   endtask

   task automatic test_reabrir();
      int abiertos, esperado;
      esperado = REOPEN ? 6 + DC : DC;
      ciclo(onehot(0), 1'b0, 1'b0);
      ciclo('0, 1'b0, 1'b0);
      abiertos = puerta_abierta ? 1 : 0;
      for (int k = 0; k < 60 && puerta_abierta; k++) begin
         ciclo('0, 1'b0, abiertos == 6);
         if (puerta_abierta) abiertos++;
      end
      checks++;
      if (abiertos != esperado) begin
         errors++; $display("FAIL t6_door_len: got %0d expected %0d", abiertos, esperado);
      end
      checks++;
      if (dut_vec !== m_vec()) begin
         errors++; $display("FAIL t6_model: got %b expected %b", dut_vec, m_vec());
      end
   endtask

   task automatic test_aleatorio();
      logic [NP-1:0] b;
      for (int k = 0; k < 2000; k++) begin
         b = '0;
         if ($urandom_range(0, 5) == 0) b = onehot(int'($urandom_range(0, NP - 1)));
         ciclo(b, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
         checks++;
         if (dut_vec !== m_vec()) begin
            errors++; $display("FAIL rand_model cycle %0d: got %b expected %b", k, dut_vec, m_vec());
         end
         checks++;
         if ((motor_subir && motor_bajar) || (puerta_abierta && (motor_subir || motor_bajar))) begin
            errors++; $display("FAIL rand_exclusive cycle %0d: got up=%b down=%b door=%b expected no overlap",
                               k, motor_subir, motor_bajar, puerta_abierta);
         end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_mismo_piso();
      test_subir();
      test_scan();
      test_ignorar();
      test_reset_viaje();
      test_reabrir();
      test_aleatorio();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
